bin2therm_ramp: RTL and testbench
=================================

# bin2therm_ramp

Parametrised, slew-limited binary-to-thermometer decoder with a valid/ready input. It accepts a binary target level and ramps an internal level register toward that target by at most `MAX_STEP` per clock. It drives a `2**DIN_W`-bit thermometer word with selectable fill direction. It sits in front of segmented thermometer DAC/driver arrays, where large single-cycle code jumps are not allowed.

## Interface
- `DIN_W`, default 8: binary input width; thermometer width is `2**DIN_W`.
- `MAX_STEP`, default 4: maximum level change per clock; legal range 1 .. `2**DIN_W-1`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `din_valid`  in  1  new target is present on `din`.
- `din_ready`  out  1  block can accept a target (IDLE).
- `din`  in  `DIN_W`  unsigned target level.
- `msb_fill`  in  1  fill direction, sampled with the target: 0 = ones from bit 0 upward, 1 = ones from bit `2**DIN_W-1` downward.
- `dout`  out  `2**DIN_W`  thermometer word for the current level.
- `level`  out  `DIN_W`  current level register.
- `busy`  out  1  ramp in progress (RAMP state).
- `done`  out  1  one-cycle pulse; the level has just reached the target.

## Operation
- Registers: `state` (IDLE/RAMP), `level_q`, `target_q`, `mode_q`, `done_q`.
- Thermometer mapping follows the family convention: level L gives L+1 ones.
  - `mode_q`=0: `dout[i] = (i <= level_q)`.
  - `mode_q`=1: `dout[2**DIN_W-1-i] = (i <= level_q)`.
- `dout` is a combinational decode of `level_q` and `mode_q` only. There is no combinational path from any input to `dout`, `level`, `busy` or `done`.
- `din_ready` = (state==IDLE); `busy` = (state==RAMP); `level` = `level_q`; `done` = `done_q`.
- IDLE:
  - On `din_valid && din_ready`: `target_q<=din`, `mode_q<=msb_fill`, state→RAMP.
  - Otherwise hold all registers.
- RAMP:
  - diff = |`target_q`-`level_q`|, computed in `DIN_W`-bit unsigned arithmetic with the sign taken from the `target_q > level_q` compare.
  - If diff ≤ `MAX_STEP`: `level_q<=target_q`, `done_q<=1`, state→IDLE.
  - Else: `level_q <= level_q ± MAX_STEP`, toward the target.
  - No overflow or wrap is possible, because an add/subtract happens only when diff > `MAX_STEP`.
- `done_q` is cleared on every edge where it is not set. It is therefore a single-cycle pulse.
- `din_valid` while busy is ignored: not accepted, not queued. The upstream block must hold `din` until it sees ready.
- Target equal to the current level: one RAMP cycle with diff=0, then `done` pulses. This is not a zero-cycle bypass.
- `mode_q` changes only on accept. A new direction takes effect on `dout` the cycle after accept, with the old level still shown in that cycle.
- Reset (`resetn`=0, at any time, including mid-ramp), asynchronously:
  - state=IDLE, `level_q`=0, `target_q`=0, `mode_q`=0, `done_q`=0.
  - Outputs: `dout`=1 (bit 0 set only), `din_ready`=1, `busy`=0, `done`=0, `level`=0.

## Timing
- Accept at edge k.
- RAMP occupies edges k+1 .. k+n, where n = max(1, ceil(diff0/`MAX_STEP`)) and diff0 is the distance at accept.
- `level_q` takes its final value at edge k+n; `done`=1 and `din_ready`=1 in the cycle after edge k+n.
- Back-to-back operation: a new target may be accepted in the same cycle `done` is high. Throughput is one target per n+1 cycles.
- `dout` changes only after rising edges, or asynchronously on reset assertion.
- Reset release is synchronised upstream. The block holds IDLE until the first `din_valid` after release.

## Test plan
- Reset values: assert `resetn`=0 mid-ramp (level 8 of 0→20) → `dout`=256'h1, `level`=0, `busy`=0, `din_ready`=1 immediately, without waiting for a clock edge.
- Up ramp (`MAX_STEP`=4): level 0, accept `din`=10 → `level` 4, 8, 10 on successive edges; `done` high one cycle with `level`=10; `dout`=11 low ones.
- Down ramp: from 10, accept `din`=0 → `level` 6, 2, 0; `done` pulses once; `dout`=256'h1.
- MSB fill: accept `din`=3, `msb_fill`=1 from level 3 → one busy cycle, `done`; `dout` top 4 bits set, all others 0.
- Busy and same-level handling: `din_valid`=1 with `din`=200 during a ramp → ignored and `target_q` unchanged; re-accept of the current level → exactly one busy cycle, then `done`.
- Full range: accept 255 from 0 → 64 busy cycles (63×4 + 3); final `dout` all ones; a new accept in the `done` cycle is taken.

Source files
------------

// File: rtl/bin2therm_ramp.sv
// Slew-limited binary-to-thermometer decoder: ramps an internal level toward an
// accepted target by at most MAX_STEP per clock and decodes it to a thermometer word.
module bin2therm_ramp #(
    parameter int unsigned DIN_W    = 8,
    parameter int unsigned MAX_STEP = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DIN_W-1:0]      din,
    input  logic                  msb_fill,
    output logic [2**DIN_W-1:0]   dout,
    output logic [DIN_W-1:0]      level,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned TW = 2**DIN_W;
    localparam logic [DIN_W-1:0] STEP = DIN_W'(MAX_STEP);

    typedef enum logic {
        S_IDLE,
        S_RAMP
    } state_t;

    state_t           state_q, state_d;
    logic [DIN_W-1:0] level_q, level_d;
    logic [DIN_W-1:0] target_q, target_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic             up;
    logic [DIN_W-1:0] diff;
    logic [TW-1:0]    therm;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            level_q  <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    // Magnitude only; direction comes from the compare, so no wider arithmetic is needed.
    assign up   = (target_q > level_q);
    assign diff = up ? (target_q - level_q) : (level_q - target_q);

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    target_d = din;
                    mode_d   = msb_fill;
                    state_d  = S_RAMP;
                end
            end
            S_RAMP: begin
                if (diff <= STEP) begin
                    level_d = target_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (up) begin
                    level_d = level_q + STEP;
                end else begin
                    level_d = level_q - STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Level L lights L+1 bits; msb mode is the bit-reversed word.
    always_comb begin
        therm = '0;
        for (int unsigned i = 0; i < TW; i++) begin
            therm[i] = (i <= 32'(level_q));
        end
    end

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < TW; i++) begin
            dout[i] = mode_q ? therm[TW-1-i] : therm[i];
        end
    end

    assign din_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RAMP);
    assign level     = level_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bin2therm_ramp.sv
// Directed bench for bin2therm_ramp (DIN_W=8, MAX_STEP=4) with hand-computed expectations.
module tb_bin2therm_ramp;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [7:0]   din = '0;
    logic         msb_fill = 1'b0;
    logic [255:0] dout;
    logic [7:0]   level;
    logic         busy;
    logic         done;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    int unsigned  busy_cycles;
    logic [255:0] all_ones;
    logic [255:0] top4;

    bin2therm_ramp #(
        .DIN_W    (8),
        .MAX_STEP (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
        .msb_fill  (msb_fill),
        .dout      (dout),
        .level     (level),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [7:0] d, input logic m);
        din       = d;
        msb_fill  = m;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        all_ones = '1;
        top4     = {4'hF, 252'h0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_dout",  dout, 256'h1);
        check("rst_level", 256'(level), 256'd0);
        check("rst_ready", 256'(din_ready), 256'd1);
        check("rst_busy",  256'(busy), 256'd0);
        check("rst_done",  256'(done), 256'd0);
        resetn = 1'b1;
        step();
        check("idle_hold", 256'(busy), 256'd0);

        // Up ramp 0 -> 10
        accept(8'd10, 1'b0);
        check("up_busy0",  256'(busy), 256'd1);
        check("up_ready0", 256'(din_ready), 256'd0);
        check("up_lvl0",   256'(level), 256'd0);
        step();
        check("up_lvl1", 256'(level), 256'd4);
        step();
        check("up_lvl2", 256'(level), 256'd8);
        step();
        check("up_lvl3",  256'(level), 256'd10);
        check("up_done",  256'(done), 256'd1);
        check("up_ready", 256'(din_ready), 256'd1);
        check("up_dout",  dout, 256'h7FF);
        step();
        check("up_done_clr", 256'(done), 256'd0);

        // Down ramp 10 -> 0, with a busy-time valid that must be ignored
        accept(8'd0, 1'b0);
        din       = 8'd200;
        din_valid = 1'b1;
        check("dn_lvl0", 256'(level), 256'd10);
        step();
        check("dn_lvl1", 256'(level), 256'd6);
        step();
        check("dn_lvl2", 256'(level), 256'd2);
        step();
        din_valid = 1'b0;
        check("dn_lvl3", 256'(level), 256'd0);
        check("dn_done", 256'(done), 256'd1);
        check("dn_dout", dout, 256'h1);
        step();
        check("dn_ignored_busy", 256'(busy), 256'd0);
        check("dn_ignored_lvl",  256'(level), 256'd0);
        check("dn_done_clr",     256'(done), 256'd0);

        // Reach level 3, then same-level accept with msb fill
        accept(8'd3, 1'b0);
        check("l3_busy", 256'(busy), 256'd1);
        step();
        check("l3_done", 256'(done), 256'd1);
        check("l3_dout", dout, 256'hF);
        accept(8'd3, 1'b1);
        check("msb_busy", 256'(busy), 256'd1);
        check("msb_dout_early", dout, top4);
        step();
        check("msb_done", 256'(done), 256'd1);
        check("msb_busy_end", 256'(busy), 256'd0);
        check("msb_dout", dout, top4);
        check("msb_lvl", 256'(level), 256'd3);

        // Back to 0 in lsb mode, then full-range ramp
        accept(8'd0, 1'b0);
        step();
        check("z_lvl", 256'(level), 256'd0);
        check("z_dout", dout, 256'h1);
        accept(8'd255, 1'b0);
        busy_cycles = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cycles++;
            step();
        end
        check("full_cycles", 256'(busy_cycles), 256'd64);
        check("full_lvl",  256'(level), 256'd255);
        check("full_done", 256'(done), 256'd1);
        check("full_dout", dout, all_ones);
        // Accept in the done cycle
        accept(8'd100, 1'b0);
        check("b2b_busy", 256'(busy), 256'd1);
        step();
        check("b2b_lvl", 256'(level), 256'd251);

        // Asynchronous reset mid-ramp (level 8 of 0 -> 20)
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        @(negedge clk);
        accept(8'd20, 1'b0);
        step();
        step();
        check("mid_lvl", 256'(level), 256'd8);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_dout",  dout, 256'h1);
        check("arst_level", 256'(level), 256'd0);
        check("arst_busy",  256'(busy), 256'd0);
        check("arst_ready", 256'(din_ready), 256'd1);
        check("arst_done",  256'(done), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
